// File: rtl/pc_gen.sv
// Fetch program-counter generator: boot delay, sequential advance, redirects latched across stalls.
// Optional MISALIGN_TRAP_EN: misaligned redirect targets are replaced by TRAP_VEC and flagged.
module pc_gen #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          BOOT_DELAY = 4,
    parameter logic [31:0] TRAP_VEC   = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        br_i,
    input  logic [31:0] br_addr_i,
    output logic [31:0] pc_o,
    output logic        ce_o,
    output logic        br_o,
    output logic        pend_o,
    output logic        misalign_o
);

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [31:0] pc_n, tgt, tgt_n;
    logic        ce_n, br_n, pend_n, mis_n, pmis, pmis_n;
    logic [31:0] in_tgt;
    logic        in_mis;

    // Incoming target with low bits cleared; misalignment only matters when trapping.
    assign in_tgt = {br_addr_i[31:2], 2'b00};
    assign in_mis = TRAP_EN && (br_addr_i[1:0] != 2'b00);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pc_n    = pc_o;
        ce_n    = ce_o;
        br_n    = 1'b0;
        mis_n   = 1'b0;
        pend_n  = pend_o;
        tgt_n   = tgt;
        pmis_n  = pmis;
        case (state)
            BOOT: begin
                cnt_n = cnt + 16'd1;
                if (BOOT_DELAY <= 1 || cnt == 16'(BOOT_DELAY - 1)) begin
                    state_n = RUN;
                    ce_n    = 1'b1;
                end
            end
            RUN: begin
                if (!stall_i) begin
                    if (br_i) begin
                        pc_n  = in_mis ? TRAP_VEC : in_tgt;
                        br_n  = 1'b1;
                        mis_n = in_mis;
                    end else begin
                        pc_n = pc_o + 32'd4;
                    end
                end else begin
                    state_n = HOLD;
                    if (br_i) begin
                        pend_n = 1'b1;
                        tgt_n  = in_tgt;
                        pmis_n = in_mis;
                    end
                end
            end
            HOLD: begin
                if (!stall_i) begin
                    state_n = RUN;
                    pend_n  = 1'b0;
                    if (br_i) begin
                        pc_n  = in_mis ? TRAP_VEC : in_tgt;
                        br_n  = 1'b1;
                        mis_n = in_mis;
                    end else if (pend_o) begin
                        pc_n  = pmis ? TRAP_VEC : tgt;
                        br_n  = 1'b1;
                        mis_n = pmis;
                    end else begin
                        pc_n = pc_o + 32'd4;
                    end
                end else if (br_i) begin
                    // Newest redirect wins while stalled.
                    pend_n = 1'b1;
                    tgt_n  = in_tgt;
                    pmis_n = in_mis;
                end
            end
            default: state_n = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= BOOT;
            cnt        <= 16'd0;
            pc_o       <= RESET_PC;
            ce_o       <= 1'b0;
            br_o       <= 1'b0;
            pend_o     <= 1'b0;
            tgt        <= 32'd0;
            pmis       <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            pc_o       <= pc_n;
            ce_o       <= ce_n;
            br_o       <= br_n;
            pend_o     <= pend_n;
            tgt        <= tgt_n;
            pmis       <= pmis_n;
            misalign_o <= mis_n;
        end
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Program-counter generator feeding the fetch stage of the five-stage core. Holds the current fetch PC, advances it by 4 each accepted fetch, and applies branch/jump redirects from downstream. Provides a post-reset boot delay and latches redirects that arrive during a stall, so no redirect is lost. Drives pc_o and br_o directly into the fetch stage's pc_i and br inputs.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
BOOT_DELAY, 4, cycles after reset release before fetch enable rises (0 allowed).
TRAP_VEC, 32'h0000_0100, redirect target for a misaligned branch (optional feature only).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge).
stall_i  in  1  downstream cannot accept the fetch at pc_o this cycle.
br_i  in  1  redirect request this cycle (taken branch/jump).
br_addr_i  in  32  redirect target.
pc_o  out  32  current fetch address.
ce_o  out  1  fetch enable; 0 during reset/boot.
br_o  out  1  one-cycle pulse: pc_o holds a freshly redirected address.
pend_o  out  1  a redirect is latched and waiting for the stall to clear.
misalign_o  out  1  one-cycle pulse on a misaligned redirect (optional feature only).

Behaviour:
- Reset (rst==0 at edge): pc_o=RESET_PC, ce_o=0, br_o=0, pend_o=0, misalign_o=0, boot counter=0, pending target=0, state=BOOT. Reset mid-operation discards any pending redirect.
- States: BOOT, RUN, HOLD. All outputs are registered.
- BOOT: counter increments each cycle. When counter==BOOT_DELAY-1, next state=RUN and ce_o<=1. BOOT_DELAY==0: the first cycle after reset release goes to RUN. pc_o stays RESET_PC. br_i and stall_i are ignored.
- RUN: the fetch at pc_o is accepted on any cycle with stall_i==0.
  - br_i=1, stall_i=0: pc_o<=target, br_o<=1, stay RUN.
  - br_i=1, stall_i=1: latch target, pend_o<=1, pc_o held, go HOLD.
  - br_i=0, stall_i=1: pc_o held, go HOLD.
  - br_i=0, stall_i=0: pc_o<=pc_o+4, stay RUN.
- HOLD: pc_o held, br_o=0.
  - br_i=1: overwrites the pending target (newest wins); pend_o<=1.
  - stall_i=0 with br_i=1: that target is applied directly, pc_o<=target, br_o<=1, pend_o<=0, go RUN.
  - stall_i=0, no br_i, pending set: pc_o<=pending target, br_o<=1, pend_o<=0, go RUN.
  - stall_i=0, nothing pending: pc_o<=pc_o+4, go RUN.
- br_o is high for exactly one cycle per applied redirect and is never high in BOOT.
- Arithmetic: 32-bit modulo. 0xFFFF_FFFC+4 wraps to 0x0000_0000 with no flag.
- Target alignment: bits [1:0] of br_addr_i are always forced to 0 before use.
- ce_o stays 1 from BOOT exit until the next reset.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a redirect with br_addr_i[1:0]!=0 is applied as TRAP_VEC instead of the masked target. misalign_o pulses high the same cycle br_o pulses. A latched misaligned target in HOLD is flagged at latch time and trapped at apply time.
- Undefined: low bits are silently cleared and misalign_o is tied 0.

Test Plan:
- Reset then release, BOOT_DELAY=4, no stall -> ce_o rises 4 cycles after release. pc_o sequence is 0x0, 0x4, 0x8, ... one per cycle; br_o stays 0.
- RUN at pc 0x20, br_i=1, br_addr_i=0x400, stall_i=0 -> next cycle pc_o=0x400, br_o=1 for one cycle, then 0x404.
- At pc 0x40, stall_i=1 for 3 cycles with br_i=1 (target 0x800) in the first of them, then stall_i=0 -> pc_o held 0x40 and pend_o=1 during the stall. Release cycle: pc_o<=0x800, br_o=1, pend_o=0.
- In HOLD, two redirects 0x100 then 0x200 before release -> pc_o=0x200 after release; exactly one br_o pulse.
- Start at pc 0xFFFF_FFF8, run 3 cycles -> 0xFFFF_FFFC, then 0x0000_0000, then 0x4.
- br_addr_i=0x103 -> pc_o=0x100 without MISALIGN_TRAP_EN. With it: pc_o=TRAP_VEC (0x100 default; bench uses TRAP_VEC=0x180) and misalign_o pulses once. Also: rst=0 while pend_o=1 -> pending cleared, pc_o=RESET_PC, state BOOT.
